stream_splitter: RTL

STREAM_SPLITTER -- requirements
Module: stream_splitter

---
 rtl/stream_splitter.sv | 107 ++++++++++
 1 files changed

// File: rtl/stream_splitter.sv
// rtl/stream_splitter.sv - one input stream steered into two independent lane FIFOs (A/B).
// Define STREAM_SPLITTER_RR_EN to alternate lanes round-robin instead of following IN_DEST.
module stream_splitter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [WIDTH-1:0]           IN_DATA,
    input  logic                       IN_DEST,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    output logic [WIDTH-1:0]           A_DATA,
    output logic                       A_VALID,
    input  logic                       A_READY,
    output logic [WIDTH-1:0]           B_DATA,
    output logic                       B_VALID,
    input  logic                       B_READY,
    output logic [$clog2(DEPTH):0]     A_COUNT,
    output logic [$clog2(DEPTH):0]     B_COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] a_mem_q [DEPTH];
    logic [WIDTH-1:0] b_mem_q [DEPTH];
    logic [AW-1:0]    a_wr_q, a_wr_d, a_rd_q, a_rd_d;
    logic [AW-1:0]    b_wr_q, b_wr_d, b_rd_q, b_rd_d;
    logic [CW-1:0]    a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;

    logic sel_b;
    logic a_full, b_full;
    logic push, push_a, push_b, pop_a, pop_b;

`ifdef STREAM_SPLITTER_RR_EN
    logic rr_q, rr_d;
    wire  unused_in_dest = IN_DEST;

    assign sel_b = rr_q;
    assign rr_d  = push ? ~rr_q : rr_q;

    always_ff @(posedge CLK) begin
        if (RST) rr_q <= 1'b0;
        else     rr_q <= rr_d;
    end
`else
    assign sel_b = IN_DEST;
`endif

    // Readiness looks only at the selected lane; a full lane never bypasses on a pop.
    assign a_full   = (a_cnt_q == FULL);
    assign b_full   = (b_cnt_q == FULL);
    assign IN_READY = sel_b ? ~b_full : ~a_full;

    assign push   = IN_VALID & IN_READY;
    assign push_a = push & ~sel_b;
    assign push_b = push & sel_b;
    assign pop_a  = A_VALID & A_READY;
    assign pop_b  = B_VALID & B_READY;

    assign A_VALID = (a_cnt_q != '0);
    assign B_VALID = (b_cnt_q != '0);
    assign A_DATA  = a_mem_q[a_rd_q];
    assign B_DATA  = b_mem_q[b_rd_q];
    assign A_COUNT = a_cnt_q;
    assign B_COUNT = b_cnt_q;

    always_comb begin
        a_wr_d  = a_wr_q;
        a_rd_d  = a_rd_q;
        b_wr_d  = b_wr_q;
        b_rd_d  = b_rd_q;
        a_cnt_d = a_cnt_q + {{AW{1'b0}}, push_a} - {{AW{1'b0}}, pop_a};
        b_cnt_d = b_cnt_q + {{AW{1'b0}}, push_b} - {{AW{1'b0}}, pop_b};
        if (push_a) a_wr_d = a_wr_q + AW'(1);
        if (pop_a)  a_rd_d = a_rd_q + AW'(1);
        if (push_b) b_wr_d = b_wr_q + AW'(1);
        if (pop_b)  b_rd_d = b_rd_q + AW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_wr_q  <= '0;
            a_rd_q  <= '0;
            b_wr_q  <= '0;
            b_rd_q  <= '0;
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            a_wr_q  <= a_wr_d;
            a_rd_q  <= a_rd_d;
            b_wr_q  <= b_wr_d;
            b_rd_q  <= b_rd_d;
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
        end
    end

    // Storage is not reset; the cleared pointers make stale contents unreachable.
    always_ff @(posedge CLK) begin
        if (!RST && push_a) a_mem_q[a_wr_q] <= IN_DATA;
        if (!RST && push_b) b_mem_q[b_wr_q] <= IN_DATA;
    end

endmodule
